// File: rtl/mul_tree_result_collector.sv
// Collects strobed bf16 lane results from the multiply tree into a circular FIFO and drains one word per cycle.
// Optional head-of-queue NaN flag is built when MUL_COLLECT_NAN_FLAG_EN is defined.
module mul_tree_result_collector #(
  parameter int DW    = 16,
  parameter int LANES = 4,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [LANES*DW-1:0]      lane_data,
  input  logic [LANES-1:0]         lane_stb,
  output logic [DW-1:0]            out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     ovf_clr,
  output logic                     out_nan
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(LANES + 1);
  localparam int LI = $clog2(LANES);
`ifdef MUL_COLLECT_NAN_FLAG_EN
  localparam int EW = DW + 1;

  function automatic logic bf16_is_nan(input logic [DW-1:0] w);
    return (&w[14:7]) && (|w[6:0]);
  endfunction

  function automatic logic [EW-1:0] pack_entry(input logic [DW-1:0] w);
    return {bf16_is_nan(w), w};
  endfunction
`else
  localparam int EW = DW;

  function automatic logic [EW-1:0] pack_entry(input logic [DW-1:0] w);
    return w;
  endfunction
`endif

  logic [EW-1:0] mem_r [DEPTH];
  logic [LW-1:0] wr_ptr_r, rd_ptr_r, level_r;
  logic [DW-1:0] out_data_r;
  logic          out_valid_r, overflow_r;

  logic [EW-1:0] pk_s [LANES];
  logic [CW-1:0] cnt_s;
  logic [LW-1:0] free_s, push_n_s, wr_next_s, rd_next_s, level_next_s;
  logic [AW-1:0] off_s;
  logic [EW-1:0] head_s;
  logic          accept_s, drop_s, pop_s;

  // Compact strobed lanes into ascending-lane order; unstrobed lanes never reach storage.
  always_comb begin
    cnt_s = '0;
    for (int j = 0; j < LANES; j++) pk_s[j] = '0;
    for (int k = 0; k < LANES; k++) begin
      if (lane_stb[k]) begin
        pk_s[cnt_s[LI-1:0]] = pack_entry(lane_data[k*DW +: DW]);
        cnt_s = cnt_s + CW'(1);
      end else begin
        cnt_s = cnt_s;
      end
    end
  end

  // Space check uses the registered level only, so a same-cycle pop never makes room.
  always_comb begin
    free_s       = LW'(DEPTH) - level_r;
    accept_s     = (cnt_s != '0) && (LW'(cnt_s) <= free_s);
    drop_s       = (cnt_s != '0) && !accept_s;
    push_n_s     = accept_s ? LW'(cnt_s) : '0;
    pop_s        = out_valid_r && out_ready;
    wr_next_s    = wr_ptr_r + push_n_s;
    rd_next_s    = rd_ptr_r + LW'(pop_s);
    level_next_s = wr_next_s - rd_next_s;
  end

  // Next head word: bypass from the incoming group when the head slot is being written this cycle.
  always_comb begin
    off_s = rd_next_s[AW-1:0] - wr_ptr_r[AW-1:0];
    if (level_next_s == '0) begin
      head_s = '0;
    end else if ((push_n_s != '0) && (LW'(off_s) < push_n_s)) begin
      head_s = pk_s[off_s[LI-1:0]];
    end else begin
      head_s = mem_r[rd_next_s[AW-1:0]];
    end
  end

  // FIFO storage write of the accepted group, wrapping modulo DEPTH.
  always_ff @(posedge clk) begin
    for (int j = 0; j < LANES; j++) begin
      if (accept_s && (CW'(j) < cnt_s)) begin
        mem_r[wr_ptr_r[AW-1:0] + AW'(j)] <= pk_s[j];
      end
    end
  end

  // Pointers, occupancy, registered head and sticky overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      level_r     <= '0;
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      wr_ptr_r    <= wr_next_s;
      rd_ptr_r    <= rd_next_s;
      level_r     <= level_next_s;
      out_data_r  <= head_s[DW-1:0];
      out_valid_r <= (level_next_s != '0);
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (ovf_clr) begin
        overflow_r <= 1'b0;
      end else begin
        overflow_r <= overflow_r;
      end
    end
  end

`ifdef MUL_COLLECT_NAN_FLAG_EN
  logic out_nan_r;

  // NaN flag travels with the head word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_nan_r <= 1'b0;
    end else begin
      out_nan_r <= head_s[DW];
    end
  end

  assign out_nan = out_nan_r;
`else
  assign out_nan = 1'b0;
`endif

  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign level     = level_r;
  assign overflow  = overflow_r;

endmodule

// File: doc/mul_tree_result_collector.md
Name: mul_tree_result_collector

Overview:
- Sits directly downstream of the bf16 multiply tree.
- Each cycle it captures up to four lane results, qualified by per-lane strobes, and packs them in lane order into a circular FIFO.
- It then drains the FIFO one DW-bit word per cycle over a valid/ready interface toward writeback or a host dump.
- It also flags drops caused by overflow.

Parameters:
- DW, 16, width of one result word in bits; bf16 is 1 sign, 8 exponent, 7 mantissa.
- LANES, 4, number of tree output lanes; fixed at 4.
- DEPTH, 16, FIFO entries; power of two, must be at least 4.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- lane_data  in  LANES*DW  tree outputs; lane k occupies [k*DW +: DW].
- lane_stb  in  LANES  per-lane valid strobes from the tree, one-cycle pulses.
- out_data  out  DW  head-of-FIFO word.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts the word when out_valid and out_ready are both high.
- level  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky; set when a strobe group is dropped.
- ovf_clr  in  1  synchronous clear of overflow.
- out_nan  out  1  head word is a bf16 NaN (see Optional Feature).

Behaviour:
- Reset (rst=0, asynchronous):
  - Read and write pointers go to 0, level=0, out_valid=0, out_data=0, overflow=0, out_nan=0.
  - Reset mid-burst discards all contents.
- Push:
  - n = popcount(lane_stb), range 0..4.
  - The strobed lanes are written in ascending lane index to consecutive slots starting at wr_ptr.
  - wr_ptr advances by n modulo DEPTH. Pointers carry one extra wrap bit.
- Space check is all-or-nothing:
  - The group is accepted only if DEPTH - level >= n.
  - level is the value registered before this cycle; a same-cycle pop does not free space for the push.
  - Otherwise the whole group is dropped, no pointer moves, and overflow is set the next cycle.
- Pop:
  - Occurs when out_valid && out_ready. rd_ptr advances by 1.
- Level update:
  - level next = level + (accepted ? n : 0) - pop.
  - A simultaneous push and pop is legal and updates level correctly.
- Output:
  - out_data and out_valid are registered from the FIFO head.
  - A word pushed in cycle N is first presentable on out_valid in cycle N+1.
  - out_valid=0 iff level=0 after the update.
  - While out_valid=1 and out_ready=0, out_data must hold stable.
- Wrap-around: a group that straddles slot DEPTH-1 continues at slot 0 in lane order.
- Empty: pop is ignored when out_valid=0.
- Strobe hygiene: lane_data bits of unstrobed lanes are don't-care and never stored.
- Overflow flag:
  - Clears only on ovf_clr=1 or reset.
  - If ovf_clr and a new drop occur in the same cycle, the drop wins and overflow stays 1.
- There is no combinational path from out_ready to out_valid.

Optional Feature:
- Macro: MUL_COLLECT_NAN_FLAG_EN.
- When defined:
  - out_nan is registered alongside out_data.
  - It is 1 iff head exponent bits [14:7] are all ones and mantissa bits [6:0] are nonzero.
  - It is valid only when out_valid=1.
  - Each NaN is detected at push time and stored as an extra FIFO bit.
- When undefined:
  - No extra storage is built.
  - out_nan is tied to 0.

Test Plan:
- Single lanes: after reset, lane_stb=4'b0001 with lane0=16'h3F80, then 4'b1000 with lane3=16'h4000, out_ready=1.
  - Expect out_valid one cycle after each push, out_data 3F80 then 4000, level returns to 0.
- Full group in order: lane_stb=4'b1111 with lanes 0..3 = 3F80, 4000, 4040, 4080, out_ready=0 for 5 cycles, then 1.
  - Expect level=4, out_data held at 3F80 while stalled, then drain 3F80, 4000, 4040, 4080 on consecutive cycles.
- Overflow: fill with four full groups (level=16), out_ready=0, then lane_stb=4'b0001.
  - Expect overflow=1 the next cycle, level stays 16, contents unchanged.
  - Pulse ovf_clr and expect overflow=0.
- Wrap and simultaneous push/pop:
  - Setup: drain to level=2 with pointers at slot 14.
  - Stimulus: push 4'b0111 (values 1111, 2222, 3333) while popping.
  - Expect slots 14, 15, 0 written; level=4; output order preserved across the wrap.
- Reset mid-operation: with level=7, drive rst=0 for one half-cycle asynchronously.
  - Expect out_valid=0, level=0 and overflow=0 immediately, and clean operation afterwards.
- NaN flag (with MUL_COLLECT_NAN_FLAG_EN defined): push 7FC1, then 7F80, then FFFF.
  - Expect out_nan = 1, 0, 1.
  - Without the macro, out_nan stays 0.
